// File: rtl/dm_load_unit_pkg.sv
// Shared CPU definitions for the data-memory load path: load op encodings,
// load FSM state encoding and the debug view of the load unit.
package cpu_pkg;

  localparam logic [2:0] LD_LW  = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LBU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } ldState_t;

  // Internal view of the load unit; pc/addr also feed the writeback trace.
  typedef struct packed {
    ldState_t    state;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] pc;
  } ldDebug_t;

endpackage

// File: rtl/dm_load_unit_if.sv
// Load-unit buses: the MEM-stage request / writeback result side and the
// data-memory read side, each with master/slave modports.
//
// Handshakes: a load transfers on a clock edge where ld_valid && ld_ready;
// ld_ready is high only when the unit is idle and the MEM stage keeps ld_valid
// and its payload stable while stall is high. A memory read is outstanding
// while mem_req is high; mem_addr holds until the edge where mem_ack is
// sampled high, and mem_rdata is valid in that same cycle. rd_valid is a
// one-cycle pulse with no back-pressure; rd_exc and rd_data qualify it.
interface dm_ld_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_op;
  logic [31:0] ld_addr;
  logic [31:0] ld_pc;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_exc;
  logic        stall;

  modport master (
    output ld_valid, ld_op, ld_addr, ld_pc,
    input  ld_ready, rd_valid, rd_data, rd_exc, stall
  );
  modport slave (
    input  ld_valid, ld_op, ld_addr, ld_pc,
    output ld_ready, rd_valid, rd_data, rd_exc, stall
  );
endinterface

interface dm_mem_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dm_load_unit_extend.sv
// Little-endian lane extraction with sign/zero extension for loads; also
// flags accesses that are misaligned for their size or use an illegal op.
module load_extend
  import cpu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addrLo,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [15:0] halfSel;
  logic [7:0]  byteSel;

  always_comb begin
    halfSel = addrLo[1] ? word[31:16] : word[15:0];
    case (addrLo)
      2'd0:    byteSel = word[7:0];
      2'd1:    byteSel = word[15:8];
      2'd2:    byteSel = word[23:16];
      default: byteSel = word[31:24];
    endcase

    data       = '0;
    misaligned = 1'b0;
    case (op)
      LD_LW: begin
        data       = word;
        misaligned = (addrLo != 2'd0);
      end
      LD_LH: begin
        data       = {{16{halfSel[15]}}, halfSel};
        misaligned = addrLo[0];
      end
      LD_LHU: begin
        data       = {16'd0, halfSel};
        misaligned = addrLo[0];
      end
      LD_LB:  data = {{24{byteSel[7]}}, byteSel};
      LD_LBU: data = {24'd0, byteSel};
      // Unknown ops are reported through the same exception path.
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// Single-outstanding load initiator: word-aligned read over req/ack, lane
// extraction, one-cycle result pulse, exception on misalign/illegal/timeout.
module dm_load_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic     clk,
  input  logic     reset,
  dm_ld_if.slave   ld,
  dm_mem_if.master mem,
  output ldDebug_t dbg
);

  ldState_t        state;
  logic [2:0]      opQ;
  logic [31:0]     addrQ;
  logic [31:0]     pcQ;
  logic [CNT_W-1:0] count;
  logic            memReq;
  logic [31:0]     memAddr;
  logic            rdValid;
  logic [31:0]     rdData;
  logic            rdExc;

  logic [2:0]  extOp;
  logic [1:0]  extAddrLo;
  logic [31:0] extData;
  logic        extBad;

  // In IDLE the extender checks the incoming request; afterwards it decodes
  // the returned word using the latched op/address.
  assign extOp     = (state == IDLE) ? ld.ld_op        : opQ;
  assign extAddrLo = (state == IDLE) ? ld.ld_addr[1:0] : addrQ[1:0];

  load_extend uExtend (
    .op        (extOp),
    .addrLo    (extAddrLo),
    .word      (mem.mem_rdata),
    .data      (extData),
    .misaligned(extBad)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      opQ     <= '0;
      addrQ   <= '0;
      pcQ     <= '0;
      count   <= '0;
      memReq  <= 1'b0;
      memAddr <= '0;
      rdValid <= 1'b0;
      rdData  <= '0;
      rdExc   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld.ld_valid) begin
            opQ   <= ld.ld_op;
            addrQ <= ld.ld_addr;
            pcQ   <= ld.ld_pc;
            count <= '0;
            if (extBad) begin
              state   <= RESP;
              rdValid <= 1'b1;
              rdExc   <= 1'b1;
              rdData  <= '0;
            end else begin
              state   <= REQ;
              memReq  <= 1'b1;
              memAddr <= {ld.ld_addr[31:2], 2'b00};
            end
          end
        end
        REQ: begin
          // An ack in the final timeout cycle still completes normally.
          if (mem.mem_ack) begin
            state   <= RESP;
            memReq  <= 1'b0;
            rdValid <= 1'b1;
            rdExc   <= 1'b0;
            rdData  <= extData;
          end else if (count == CNT_W'(TIMEOUT - 1)) begin
            state   <= RESP;
            memReq  <= 1'b0;
            rdValid <= 1'b1;
            rdExc   <= 1'b1;
            rdData  <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        RESP: begin
          state   <= IDLE;
          rdValid <= 1'b0;
          rdExc   <= 1'b0;
          count   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ld.ld_ready    = (state == IDLE);
  assign ld.stall       = (state != IDLE);
  assign ld.rd_valid    = rdValid;
  assign ld.rd_data     = rdData;
  assign ld.rd_exc      = rdExc;
  assign mem.mem_req    = memReq;
  assign mem.mem_addr   = memAddr;

  assign dbg.state = state;
  assign dbg.op    = opQ;
  assign dbg.addr  = addrQ;
  assign dbg.pc    = pcQ;

endmodule

// File: tb/tb_dm_load_unit.sv
// Bench for dm_load_unit: directed lane/extension, exception, timeout and
// reset cases, then random loads checked against an arithmetic load model.
module tb_dm_load_unit;
  import cpu_pkg::*;

  localparam int TB_TIMEOUT = 15;

  logic     clk;
  logic     reset;
  ldDebug_t dbg;

  dm_ld_if  ldBus ();
  dm_mem_if memBus ();

  dm_load_unit #(.TIMEOUT(TB_TIMEOUT), .CNT_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .ld   (ldBus),
    .mem  (memBus),
    .dbg  (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [32:0] expQ[$];   // {exc, data}

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void refLoad(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] word,
                                  output logic [31:0] data, output logic exc);
    int unsigned sh;
    logic [31:0] v;
    sh   = 8 * (addr % 4);
    v    = word >> sh;
    exc  = 1'b0;
    data = 32'd0;
    case (op)
      3'd1: if (addr % 4 != 0) exc = 1'b1; else data = word;
      3'd2, 3'd4: begin
        if (addr % 2 != 0) exc = 1'b1;
        else begin
          data = v & 32'hFFFF;
          if (op == 3'd2 && data >= 32'h8000) data = data - 32'h10000;
        end
      end
      3'd3, 3'd5: begin
        data = v & 32'hFF;
        if (op == 3'd3 && data >= 32'h80) data = data - 32'h100;
      end
      default: exc = 1'b1;
    endcase
  endfunction

  // ---------------- driver / memory responder ----------------
  // ackAfter: REQ cycles without ack before the ack cycle; <0 never acks.
  task automatic runLoad(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] word, input int ackAfter);
    logic [31:0] expData;
    logic        expExc;
    logic        badReq;
    logic [32:0] e;
    logic [31:0] pc;
    int          reqCycles;
    int          rdCycle;
    int          expLat;
    int          expReq;

    refLoad(op, addr, word, expData, expExc);
    badReq = expExc;
    if (badReq) begin
      expLat = 1;
      expReq = 0;
    end else if (ackAfter >= 0 && ackAfter < TB_TIMEOUT) begin
      expLat = ackAfter + 2;
      expReq = ackAfter + 1;
    end else begin
      expExc  = 1'b1;
      expData = 32'd0;
      expLat  = TB_TIMEOUT + 1;
      expReq  = TB_TIMEOUT;
    end
    expQ.push_back({expExc, expData});

    pc = $urandom;
    @(negedge clk);
    checkVal("ready_idle", {31'd0, ldBus.ld_ready}, 32'd1);
    ldBus.ld_valid    = 1'b1;
    ldBus.ld_op       = op;
    ldBus.ld_addr     = addr;
    ldBus.ld_pc       = pc;
    memBus.mem_ack    = 1'($urandom_range(0, 1));
    memBus.mem_rdata  = $urandom;

    reqCycles = 0;
    rdCycle   = 0;
    for (int cyc = 1; cyc <= 40 && rdCycle == 0; cyc++) begin
      @(negedge clk);
      checkVal("stall_busy", {31'd0, ldBus.stall}, 32'd1);
      // Junk requests while busy must be ignored.
      ldBus.ld_valid = 1'($urandom_range(0, 1));
      ldBus.ld_op    = 3'($urandom_range(0, 7));
      ldBus.ld_addr  = $urandom;
      if (memBus.mem_req) begin
        reqCycles++;
        if (reqCycles == 1)
          checkVal("mem_addr", memBus.mem_addr, {addr[31:2], 2'b00});
        memBus.mem_ack   = (reqCycles == ackAfter + 1);
        memBus.mem_rdata = memBus.mem_ack ? word : $urandom;
      end else begin
        memBus.mem_ack   = 1'($urandom_range(0, 1));
        memBus.mem_rdata = $urandom;
      end
      if (ldBus.rd_valid) begin
        rdCycle = cyc;
        e = expQ.pop_front();
        checkVal("rd_data", ldBus.rd_data, e[31:0]);
        checkVal("rd_exc", {31'd0, ldBus.rd_exc}, {31'd0, e[32]});
        if (!ldBus.rd_exc)
          $display("@%h: %h <= *%h", dbg.pc, ldBus.rd_data, dbg.addr);
      end
    end
    ldBus.ld_valid = 1'b0;

    if (rdCycle == 0) begin
      checkVal("rd_valid_seen", 32'd0, 32'd1);
      if (expQ.size() > 0) void'(expQ.pop_front());
    end else begin
      checkVal("latency", rdCycle, expLat);
    end
    checkVal("req_cycles", reqCycles, expReq);

    @(negedge clk);
    checkVal("rd_pulse", {31'd0, ldBus.rd_valid}, 32'd0);
    checkVal("ready_after", {31'd0, ldBus.ld_ready}, 32'd1);
    checkVal("stall_after", {31'd0, ldBus.stall}, 32'd0);
  endtask

  task automatic resetMidReq();
    @(negedge clk);
    ldBus.ld_valid = 1'b1;
    ldBus.ld_op    = LD_LW;
    ldBus.ld_addr  = 32'h0000_0020;
    ldBus.ld_pc    = 32'h0000_1000;
    memBus.mem_ack = 1'b0;
    @(negedge clk);
    ldBus.ld_valid = 1'b0;
    checkVal("rst_pre_req", {31'd0, memBus.mem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkVal("rst_req_drop", {31'd0, memBus.mem_req}, 32'd0);
    checkVal("rst_ready", {31'd0, ldBus.ld_ready}, 32'd1);
    reset            = 1'b0;
    memBus.mem_ack   = 1'b1;
    memBus.mem_rdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      memBus.mem_ack = 1'b0;
      checkVal("rst_no_valid", {31'd0, ldBus.rd_valid}, 32'd0);
      checkVal("rst_no_req", {31'd0, memBus.mem_req}, 32'd0);
      checkVal("rst_idle", {31'd0, ldBus.ld_ready}, 32'd1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset            = 1'b1;
    ldBus.ld_valid   = 1'b0;
    ldBus.ld_op      = 3'd0;
    ldBus.ld_addr    = 32'd0;
    ldBus.ld_pc      = 32'd0;
    memBus.mem_ack   = 1'b0;
    memBus.mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_mem_req", {31'd0, memBus.mem_req}, 32'd0);
    checkVal("rst_mem_addr", memBus.mem_addr, 32'd0);
    checkVal("rst_rd_valid", {31'd0, ldBus.rd_valid}, 32'd0);
    checkVal("rst_rd_data", ldBus.rd_data, 32'd0);
    checkVal("rst_rd_exc", {31'd0, ldBus.rd_exc}, 32'd0);
    checkVal("rst_ld_ready", {31'd0, ldBus.ld_ready}, 32'd1);
    checkVal("rst_stall", {31'd0, ldBus.stall}, 32'd0);
    reset = 1'b0;

    runLoad(LD_LW,  32'h0000_0004, 32'h8765_4321, 2);
    runLoad(LD_LB,  32'h0000_000B, 32'h80FF_1234, 1);
    runLoad(LD_LBU, 32'h0000_000B, 32'h80FF_1234, 0);
    runLoad(LD_LB,  32'h0000_0008, 32'h80FF_1234, 3);
    runLoad(LD_LH,  32'h0000_000A, 32'h8001_7FFF, 0);
    runLoad(LD_LHU, 32'h0000_0008, 32'h8001_7FFF, 1);
    runLoad(LD_LH,  32'h0000_0008, 32'h8001_7FFF, 2);
    runLoad(LD_LW,  32'h0000_0006, 32'h1111_1111, 0);
    runLoad(LD_LH,  32'h0000_0001, 32'h2222_2222, 0);
    runLoad(3'd6,   32'h0000_0000, 32'h3333_3333, 0);
    runLoad(LD_LW,  32'h0000_0010, 32'hDEAD_BEEF, -1);
    runLoad(LD_LW,  32'h0000_0010, 32'hCAFE_F00D, TB_TIMEOUT - 1);

    resetMidReq();

    for (int n = 0; n < 60; n++) begin
      int ack;
      ack = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      runLoad(3'($urandom_range(0, 7)), $urandom, $urandom, ack);
    end

    checkVal("sb_empty", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_load_unit.md
Name: dm_load_unit

Overview:
- CPU-side load initiator for the word-organised data memory, which already implements word/half/byte stores.
- Accepts one load at a time from the MEM stage and issues a word-aligned read over a req/ack handshake.
- Extracts the byte or halfword lane from the returned word and sign- or zero-extends it.
- Returns the result to writeback with a one-cycle valid pulse. Flags misalignment and memory timeout as exceptions.

Parameters:
TIMEOUT, 15, cycles in REQ without mem_ack before the load aborts with exception; legal range 1..255
CNT_W, 8, timeout counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ld_valid  in  1  load request from MEM stage
ld_ready  out  1  unit can accept a request (IDLE only)
ld_op  in  3  load op: 1 lw, 2 lh, 3 lb, 4 lhu, 5 lbu; any other value is illegal
ld_addr  in  32  byte address
ld_pc  in  32  PC of the load instruction, latched for the trace
mem_req  out  1  read request to data memory
mem_addr  out  32  word-aligned read address {addr[31:2],2'b00}
mem_ack  in  1  memory response; mem_rdata is valid in the same cycle
mem_rdata  in  32  read word
rd_valid  out  1  one-cycle result pulse
rd_data  out  32  extended load result
rd_exc  out  1  exception qualifier with rd_valid (misaligned, illegal op, or timeout)
stall  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, REQ, RESP.
- Reset: state IDLE, mem_req 0, mem_addr 0, rd_valid 0, rd_data 0, rd_exc 0, counter 0, latched op/addr/pc 0.
- Registered outputs: mem_req, mem_addr, rd_valid, rd_data, rd_exc.
- ld_ready is combinational (state==IDLE). stall is combinational (state!=IDLE).
- IDLE, ld_valid & ld_ready:
  - Latch op, addr and pc.
  - Error condition: op illegal, or lw with addr[1:0]!=0, or lh/lhu with addr[0]!=0.
  - On error: go to RESP with rd_exc=1, rd_data=0. mem_req is never raised.
  - Otherwise: go to REQ, with mem_req=1 and mem_addr aligned in the following cycle.
- REQ:
  - mem_req and mem_addr are held stable until the ack.
  - Counter increments each cycle.
  - mem_ack=1: capture the extracted mem_rdata, drop mem_req at the next edge, go to RESP with rd_exc=0.
  - Counter reaches TIMEOUT with no ack: drop mem_req, go to RESP with rd_exc=1, rd_data=0.
  - Ack and timeout in the same cycle: ack wins.
- RESP:
  - rd_valid=1 for exactly one cycle, then IDLE and counter cleared.
  - At that point $display("@%h: %h <= *%h", pc, rd_data, addr) is issued for non-exception loads.
- Minimum latency: 3 cycles from accept to rd_valid (accept, REQ with same-cycle ack, RESP).
- A new request is accepted only in IDLE; no overlap.
- Extraction is little-endian, consistent with the store path:
  - lh/lhu: addr[1]=0 selects [15:0]; addr[1]=1 selects [31:16].
  - lb/lbu: byte k=addr[1:0] selects [8k+7:8k].
  - lh/lb sign-extend; lhu/lbu zero-extend.
- mem_ack outside REQ is ignored; no state change.
- Reset mid-operation:
  - Next edge gives IDLE and mem_req 0.
  - No rd_valid is produced.
  - A late ack is ignored.
- ld_valid while busy is ignored. The upstream stage must hold it under stall.

Decomposition:
- Shared package (cpu_pkg): ld_op encodings (LD_LW=1, LD_LH=2, LD_LB=3, LD_LHU=4, LD_LBU=5) and the state encoding.
- One natural sub-module: load_extend, purely combinational, taking (op, addr[1:0], word) and returning (data, misaligned). It is reused by a future writeback bypass.

Test Plan:
- lw 0x00000004; memory acks after 2 REQ cycles with 0x87654321 -> mem_addr=0x00000004, rd_valid pulse, rd_data=0x87654321, rd_exc=0.
- Word 0x80FF1234 at addr 0x00000008:
  - lb 0x0000000B -> 0xFFFFFF80.
  - lbu 0x0000000B -> 0x00000080.
  - lb 0x00000008 -> 0x00000034.
- Word 0x80017FFF:
  - lh 0x0000000A -> 0xFFFF8001.
  - lhu 0x00000008 -> 0x00007FFF.
  - lh 0x00000008 -> 0x00007FFF.
- Misaligned lw 0x00000006, lh 0x00000001, and op=6 -> mem_req never asserted; rd_valid with rd_exc=1, rd_data=0, two cycles after accept.
- No ack, TIMEOUT=15 -> mem_req high exactly 15 cycles, then rd_exc=1 pulse. Ack on cycle 15 -> normal data, rd_exc=0.
- reset asserted during REQ -> mem_req 0 next cycle, no rd_valid, ack one cycle later ignored, ld_ready=1.
